// File: rtl/bg_line_renderer.sv
`default_nettype none
// ============================================================================
// Module      : bg_line_renderer
// Description : Background/window scanline renderer. On each line_start it
//               fetches tile-map entries and tile planes from VRAM, applies
//               fine scroll and the window layer, and writes 2-bit colour
//               indices into the render half of a ping-pong line buffer.
//               The display half is read through a registered, palette-mapped
//               pixel port.
// Revision    : 1.0 - initial release
// ============================================================================
module bg_line_renderer #(
    parameter int LINE_PIXELS = 160,
    parameter int WIN_EN      = 1
) (
    input  logic        clk_cpu,
    input  logic        rst,
    input  logic        line_start,
    input  logic [7:0]  line_y,
    input  logic [7:0]  lcdc,
    input  logic [7:0]  scx,
    input  logic [7:0]  scy,
    input  logic [7:0]  wx,
    input  logic [7:0]  wy,
    input  logic [7:0]  bgp,
    output logic        busy,
    output logic        line_done,
    output logic        vram_req,
    output logic [12:0] vram_addr,
    input  logic        vram_ack,
    input  logic [7:0]  vram_data,
    input  logic        swap,
    input  logic [7:0]  rd_x,
    output logic [1:0]  rd_idx,
    output logic [1:0]  rd_shade
);
    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_MAP  = 3'd1;
    localparam logic [2:0] c_LO   = 3'd2;
    localparam logic [2:0] c_HI   = 3'd3;
    localparam logic [2:0] c_PUSH = 3'd4;
    localparam logic [2:0] c_DONE = 3'd5;

    localparam logic [8:0] c_WX_MAX  = 9'(LINE_PIXELS + 6);
    localparam logic [8:0] c_LINE_PX = 9'(LINE_PIXELS);
    localparam logic [7:0] c_LAST_PX = 8'(LINE_PIXELS - 1);

    logic [2:0] r_state, w_next_state;
    logic       r_bg_en, r_map_bg, r_tile_sel, r_win_on, r_map_win;
    logic [4:0] r_scx_tile;
    logic [7:0] r_wx, r_wy, r_line_y, r_ybg, r_win_line;
    logic [7:0] r_idx, r_lo, r_hi, r_px;
    logic [4:0] r_tx;
    logic [2:0] r_bit, r_discard;
    logic       r_layer;
    logic       r_sel, r_pend;
    logic [1:0] r_buf0 [0:LINE_PIXELS-1];
    logic [1:0] r_buf1 [0:LINE_PIXELS-1];

    logic       w_accept, w_win_ok, w_trigger, w_write, w_line_end, w_tile_end;
    logic [7:0] w_ws, w_yrow;
    logic [2:0] w_win_disc;
    logic [4:0] w_bg_tile;
    logic [1:0] w_bank, w_colour, w_rd_raw, w_rd_shade;
    logic       w_unused_lcdc;

    assign w_unused_lcdc = ^lcdc[2:1];
    assign w_accept   = (r_state == c_IDLE) && line_start && lcdc[7];
    assign w_ws       = (r_wx < 8'd7) ? 8'd0 : r_wx - 8'd7;
    assign w_win_disc = (r_wx < 8'd7) ? 3'd7 - r_wx[2:0] : 3'd0;
    assign w_trigger  = (r_state == c_PUSH) && w_win_ok && !r_layer && (r_px == w_ws);
    assign w_colour   = {r_hi[3'd7 - r_bit], r_lo[3'd7 - r_bit]} & {2{r_bg_en}};
    assign w_write    = (r_state == c_PUSH) && !w_trigger && (r_discard == 3'd0);
    assign w_line_end = w_write && (r_px == c_LAST_PX);
    assign w_tile_end = (r_bit == 3'd7);
    assign w_yrow     = r_layer ? r_win_line : r_ybg;
    assign w_bg_tile  = r_scx_tile + r_tx;
    assign w_bank     = r_tile_sel ? {1'b0, r_idx[7]} : {~r_idx[7], r_idx[7]};

    // Window layer qualifier; tied off entirely when the layer is not built
    generate
        if (WIN_EN != 0) begin : g_win
            assign w_win_ok = r_win_on && (r_line_y >= r_wy) && ({1'b0, r_wx} <= c_WX_MAX);
        end else begin : g_no_win
            logic w_unused_win;
            assign w_unused_win = ^{r_win_on, r_wy, r_line_y};
            assign w_win_ok = 1'b0;
        end
    endgenerate

    // State register
    always_ff @(posedge clk_cpu) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic: each VRAM read advances only on an acknowledged cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: if (w_accept) w_next_state = c_MAP;
            c_MAP:  if (vram_ack) w_next_state = c_LO;
            c_LO:   if (vram_ack) w_next_state = c_HI;
            c_HI:   if (vram_ack) w_next_state = c_PUSH;
            c_PUSH: begin
                if (w_trigger)       w_next_state = c_MAP;
                else if (w_line_end) w_next_state = c_DONE;
                else if (w_tile_end) w_next_state = c_MAP;
            end
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Outputs decoded from state: status flags and VRAM request/address
    always_comb begin
        busy      = 1'b0;
        line_done = 1'b0;
        vram_req  = 1'b0;
        vram_addr = 13'd0;
        case (r_state)
            c_MAP: begin
                busy     = 1'b1;
                vram_req = 1'b1;
                vram_addr = r_layer ? {2'b11, r_map_win, r_win_line[7:3], r_tx}
                                    : {2'b11, r_map_bg, r_ybg[7:3], w_bg_tile};
            end
            c_LO, c_HI: begin
                busy      = 1'b1;
                vram_req  = 1'b1;
                vram_addr = {w_bank, r_idx[6:0], w_yrow[2:0], (r_state == c_HI)};
            end
            c_PUSH: busy = 1'b1;
            c_DONE: line_done = 1'b1;
            default: ;
        endcase
    end

    // Line datapath: latch line parameters, capture fetches, walk pixels
    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            r_bg_en <= 1'b0; r_map_bg <= 1'b0; r_tile_sel <= 1'b0;
            r_win_on <= 1'b0; r_map_win <= 1'b0; r_scx_tile <= 5'd0;
            r_wx <= 8'd0; r_wy <= 8'd0; r_line_y <= 8'd0; r_ybg <= 8'd0;
            r_win_line <= 8'd0; r_idx <= 8'd0; r_lo <= 8'd0; r_hi <= 8'd0;
            r_px <= 8'd0; r_tx <= 5'd0; r_bit <= 3'd0; r_discard <= 3'd0;
            r_layer <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: if (w_accept) begin
                    r_bg_en    <= lcdc[0];
                    r_map_bg   <= lcdc[3];
                    r_tile_sel <= lcdc[4];
                    r_win_on   <= lcdc[5];
                    r_map_win  <= lcdc[6];
                    r_scx_tile <= scx[7:3];
                    r_wx       <= wx;
                    r_wy       <= wy;
                    r_line_y   <= line_y;
                    r_ybg      <= scy + line_y;
                    r_px       <= 8'd0;
                    r_tx       <= 5'd0;
                    r_bit      <= 3'd0;
                    r_discard  <= scx[2:0];
                    r_layer    <= 1'b0;
                    if (line_y == 8'd0) r_win_line <= 8'd0;
                end
                c_MAP: if (vram_ack) r_idx <= vram_data;
                c_LO:  if (vram_ack) r_lo  <= vram_data;
                c_HI:  if (vram_ack) r_hi  <= vram_data;
                c_PUSH: begin
                    if (w_trigger) begin
                        // Abandon the current BG tile and restart on the window map
                        r_layer   <= 1'b1;
                        r_tx      <= 5'd0;
                        r_bit     <= 3'd0;
                        r_discard <= w_win_disc;
                    end else begin
                        if (r_discard != 3'd0) r_discard <= r_discard - 3'd1;
                        else                   r_px      <= r_px + 8'd1;
                        r_bit <= r_bit + 3'd1;
                        if (w_tile_end) r_tx <= r_tx + 5'd1;
                    end
                end
                c_DONE: if (r_layer) r_win_line <= r_win_line + 8'd1;
                default: ;
            endcase
        end
    end

    // Buffer select: immediate toggle when idle, deferred to DONE while rendering
    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            r_sel  <= 1'b0;
            r_pend <= 1'b0;
        end else if (r_state == c_DONE) begin
            if (swap || r_pend) r_sel <= ~r_sel;
            r_pend <= 1'b0;
        end else if (busy) begin
            if (swap) r_pend <= 1'b1;
        end else if (swap) begin
            r_sel <= ~r_sel;
        end
    end

    // Pixel writes into the render half (contents are never cleared)
    always_ff @(posedge clk_cpu) begin
        if (w_write) begin
            if (r_sel) r_buf1[r_px] <= w_colour;
            else       r_buf0[r_px] <= w_colour;
        end
    end

    assign w_rd_raw   = ({1'b0, rd_x} < c_LINE_PX) ? (r_sel ? r_buf0[rd_x] : r_buf1[rd_x]) : 2'b00;
    assign w_rd_shade = bgp[{w_rd_raw, 1'b1} -: 2];

    // Registered display read port with palette mapping
    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            rd_idx   <= 2'b00;
            rd_shade <= 2'b00;
        end else begin
            rd_idx   <= w_rd_raw;
            rd_shade <= w_rd_shade;
        end
    end

endmodule
`default_nettype wire
